// File: rtl/gamesystem_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// The CPU side uses the master modport and the timer uses the slave modport.
interface gamesystem_multi_timer_if #(
  parameter int NUM_CH = 4
);
  logic [4:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq, irq_vec
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq, irq_vec
  );
endinterface

// File: rtl/gamesystem_multi_timer.sv
// NUM_CH independent prescaled down-counters behind one Avalon-MM slave port.
// Each channel has a sticky timeout flag and its own interrupt; irq is the OR of them.
module gamesystem_multi_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49
) (
  input logic                    clk,
  input logic                    reset,
  gamesystem_multi_timer_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_DEF = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  logic              w_wr;
  logic [2:0]        w_ch;
  logic [1:0]        w_reg;

  logic [NUM_CH-1:0] w_wrCtrl;
  logic [NUM_CH-1:0] w_wrStat;
  logic [NUM_CH-1:0] w_wrPer;
  logic [NUM_CH-1:0] w_wrSnap;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_stop;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_timeout;
  logic [7:0]        w_preNext [NUM_CH];
  logic [31:0]       w_rdata;

  logic [NUM_CH-1:0] r_ito;
  logic [NUM_CH-1:0] r_cont;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_reload;
  logic [7:0]        r_prescale [NUM_CH];
  logic [7:0]        r_pcnt     [NUM_CH];
  logic [CNT_W-1:0]  r_cnt      [NUM_CH];
  logic [CNT_W-1:0]  r_period   [NUM_CH];
  logic [CNT_W-1:0]  r_snap     [NUM_CH];
  logic [31:0]       r_rdata;

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_ch  = bus.address[4:2];
  assign w_reg = bus.address[1:0];

  // Channel indices at or above NUM_CH never match, so those writes vanish.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_wrCtrl[i]  = w_wr && (int'(w_ch) == i) && (w_reg == 2'd0);
      w_wrStat[i]  = w_wr && (int'(w_ch) == i) && (w_reg == 2'd1);
      w_wrPer[i]   = w_wr && (int'(w_ch) == i) && (w_reg == 2'd2);
      w_wrSnap[i]  = w_wr && (int'(w_ch) == i) && (w_reg == 2'd3);
      w_start[i]   = w_wrCtrl[i] & bus.writedata[2];
      w_stop[i]    = w_wrCtrl[i] & bus.writedata[3];
      w_tick[i]    = r_run[i] & ~r_reload[i] & (r_pcnt[i] == 8'd0);
      w_timeout[i] = w_tick[i] & (r_cnt[i] == '0);
      w_preNext[i] = w_wrCtrl[i] ? bus.writedata[15:8] : r_prescale[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ito    <= '0;
      r_cont   <= '0;
      r_run    <= '0;
      r_to     <= '0;
      r_reload <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_prescale[i] <= 8'd0;
        r_pcnt[i]     <= 8'd0;
        r_cnt[i]      <= LP_DEF;
        r_period[i]   <= LP_DEF;
        r_snap[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wrCtrl[i]) begin
          r_ito[i]      <= bus.writedata[0];
          r_cont[i]     <= bus.writedata[1];
          r_prescale[i] <= bus.writedata[15:8];
        end
        if (w_wrPer[i]) begin
          r_period[i] <= bus.writedata[CNT_W-1:0];
        end
        r_reload[i] <= w_wrPer[i];
        if (w_wrSnap[i]) begin
          r_snap[i] <= r_cnt[i];
        end

        if (r_reload[i] || w_timeout[i]) begin
          r_cnt[i] <= r_period[i];
        end else if (w_tick[i]) begin
          r_cnt[i] <= r_cnt[i] - LP_ONE;
        end

        // An idle prescaler tracks the freshest PRESCALE so a combined write+START counts correctly.
        if (r_reload[i] || !r_run[i]) begin
          r_pcnt[i] <= w_preNext[i];
        end else if (r_pcnt[i] == 8'd0) begin
          r_pcnt[i] <= r_prescale[i];
        end else begin
          r_pcnt[i] <= r_pcnt[i] - 8'd1;
        end

        if (w_start[i]) begin
          r_run[i] <= 1'b1;
        end else if (r_reload[i] || w_stop[i] || (w_timeout[i] && !r_cont[i])) begin
          r_run[i] <= 1'b0;
        end

        if (w_timeout[i]) begin
          r_to[i] <= 1'b1;
        end else if (w_wrStat[i] && bus.writedata[0]) begin
          r_to[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(w_ch) == i) begin
        case (w_reg)
          2'd0:    w_rdata = {16'd0, r_prescale[i], 6'd0, r_cont[i], r_ito[i]};
          2'd1:    w_rdata = {30'd0, r_run[i], r_to[i]};
          2'd2:    w_rdata[CNT_W-1:0] = r_period[i];
          default: w_rdata[CNT_W-1:0] = r_snap[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.readdata = r_rdata;
  assign bus.irq_vec  = r_to & r_ito;
  assign bus.irq      = |(r_to & r_ito);

endmodule

// File: tb/tb_gamesystem_multi_timer.sv
// Directed plus randomized checks of the multi-channel timer against an arithmetic
// model: timeouts land (PERIOD+1)*(PRESCALE+1) clocks after START.
module tb_gamesystem_multi_timer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gamesystem_multi_timer_if #(.NUM_CH(4)) bus ();

  gamesystem_multi_timer #(
    .NUM_CH(4),
    .CNT_W(32),
    .DEFAULT_PERIOD(49)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns the number of the clock edge that sampled the write.
  task automatic busWrite(input int ch, input int rg, input logic [31:0] d, output int edgeNo);
    @(negedge clk);
    bus.address    = 5'(ch * 4 + rg);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    edgeNo = cyc;
  endtask

  task automatic busRead(input int ch, input int rg, output logic [31:0] d, output int edgeNo);
    @(negedge clk);
    bus.address    = 5'(ch * 4 + rg);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    d      = bus.readdata;
    edgeNo = cyc;
  endtask

  task automatic idleTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitVec(input int bitIdx, input int bound, output int edgeNo);
    edgeNo = -1;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      #1;
      if (bus.irq_vec[bitIdx]) begin
        edgeNo = cyc;
        break;
      end
    end
  endtask

  // n = clock edges seen with RUN=1 since START; one counter tick per PRESCALE+1 edges.
  function automatic bit expTimed(input int n, input int p, input int s);
    return (n / (s + 1)) >= (p + 1);
  endfunction

  function automatic int expCount(input int n, input int p, input int s, input bit cont);
    int t;
    t = n / (s + 1);
    if (!cont && t >= p + 1) return p;
    return p - (t % (p + 1));
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus();
    logic [31:0] rd;
    int e, w, x, r, t1, t2, nTo;
    int ch, p, s, gap, d;
    bit cont;
    logic [31:0] ctrl;
    int expPer[4];

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset readdata", bus.readdata, 32'd0);
    checkOutput("reset irq", {31'd0, bus.irq}, 32'd0);
    checkOutput("reset irq_vec", {28'd0, bus.irq_vec}, 32'd0);
    reset = 1'b0;
    busRead(0, 2, rd, r);
    checkOutput("ch0 default period", rd, 32'd49);
    busRead(0, 1, rd, r);
    checkOutput("ch0 status after reset", rd, 32'd0);

    // ch1 continuous, PERIOD=9, no prescale
    busWrite(1, 2, 32'd9, w);
    busWrite(1, 0, 32'h0007, e);
    waitVec(1, 40, t1);
    checkOutput("ch1 first timeout delay", 32'(t1 - e), 32'd10);
    checkOutput("ch1 irq follows", {31'd0, bus.irq}, 32'd1);
    busWrite(1, 1, 32'd1, x);
    checkOutput("ch1 irq_vec cleared", {31'd0, bus.irq_vec[1]}, 32'd0);
    checkOutput("irq cleared", {31'd0, bus.irq}, 32'd0);
    waitVec(1, 40, t2);
    checkOutput("ch1 second timeout delay", 32'(t2 - e), 32'd20);

    // ch2 one-shot, PERIOD=3, PRESCALE=4
    busWrite(2, 2, 32'd3, w);
    busWrite(2, 0, 32'h0405, e);
    waitVec(2, 60, t1);
    checkOutput("ch2 oneshot timeout delay", 32'(t1 - e), 32'd20);
    busRead(2, 1, rd, r);
    checkOutput("ch2 status after oneshot", rd, 32'd1);
    busWrite(2, 3, 32'd0, x);
    busRead(2, 3, rd, r);
    checkOutput("ch2 snapshot after oneshot", rd, 32'd3);
    busRead(2, 0, rd, r);
    checkOutput("ch2 control readback", rd, 32'h0401);
    busWrite(2, 1, 32'd1, x);

    // ch0 stop/resume/period-reload
    busWrite(0, 2, 32'd100, w);
    busWrite(0, 0, 32'h0004, e);
    idleTo(e + 39);
    busWrite(0, 0, 32'h0008, x);
    busWrite(0, 3, 32'd0, x);
    busRead(0, 3, rd, r);
    checkOutput("ch0 snapshot after stop", rd, 32'd60);
    busRead(0, 1, rd, r);
    checkOutput("ch0 status after stop", rd, 32'd0);
    busWrite(0, 0, 32'h0004, e);
    idleTo(e + 10);
    busWrite(0, 3, 32'd0, x);
    busRead(0, 3, rd, r);
    checkOutput("ch0 snapshot after resume", rd, 32'd50);
    busWrite(0, 2, 32'd20, w);
    @(posedge clk);
    #1;
    busRead(0, 1, rd, r);
    checkOutput("ch0 status after period write", rd, 32'd0);
    busWrite(0, 3, 32'd0, x);
    busRead(0, 3, rd, r);
    checkOutput("ch0 counter reloaded", rd, 32'd20);

    // ch1 W1C landing on the exact timeout edge
    nTo = e;
    busRead(1, 1, rd, r);
    nTo = t2 + 10 * ((cyc - t2) / 10 + 1);
    if (nTo - cyc < 6) nTo += 10;
    idleTo(nTo - 4);
    busWrite(1, 1, 32'd1, x);
    checkOutput("ch1 cleared before event", {31'd0, bus.irq_vec[1]}, 32'd0);
    idleTo(nTo - 1);
    busWrite(1, 1, 32'd1, x);
    checkOutput("w1c edge matches timeout", 32'(x), 32'(nTo));
    checkOutput("ch1 set wins over clear", {31'd0, bus.irq_vec[1]}, 32'd1);
    checkOutput("irq held on set/clear clash", {31'd0, bus.irq}, 32'd1);
    busWrite(1, 0, 32'h0008, x);
    busWrite(1, 1, 32'd1, x);

    // out-of-range channel 6
    busWrite(6, 2, 32'd5, x);
    busWrite(6, 0, 32'h0007, x);
    busRead(6, 2, rd, r);
    checkOutput("ch6 read is zero", rd, 32'd0);
    expPer = '{20, 9, 3, 49};
    for (int i = 0; i < 4; i++) begin
      busRead(i, 2, rd, r);
      checkOutput($sformatf("period ch%0d untouched", i), rd, 32'(expPer[i]));
    end
    checkOutput("irq idle after ch6 writes", {31'd0, bus.irq}, 32'd0);

    // randomized single-channel runs checked with the arithmetic model
    for (int trial = 0; trial < 10; trial++) begin
      ch   = $urandom_range(0, 3);
      p    = $urandom_range(0, 7);
      s    = $urandom_range(0, 3);
      cont = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 1);
      d    = $urandom_range(0, 40);
      ctrl = (32'(s) << 8) | 32'h4 | (32'(cont) << 1) | 32'h1;
      busWrite(ch, 1, 32'd1, x);
      busWrite(ch, 2, 32'(p), w);
      if (gap != 0) begin
        @(posedge clk);
        #1;
      end
      busWrite(ch, 0, ctrl, e);
      repeat (d) begin
        @(posedge clk);
        #1;
      end
      busWrite(ch, 3, 32'd0, x);
      busRead(ch, 3, rd, r);
      checkOutput($sformatf("rand%0d snapshot", trial), rd, 32'(expCount(x - 1 - e, p, s, cont)));
      checkOutput($sformatf("rand%0d irq_vec", trial), {28'd0, bus.irq_vec},
                  expTimed(r - e, p, s) ? (32'd1 << ch) : 32'd0);
      busRead(ch, 1, rd, r);
      checkOutput($sformatf("rand%0d status", trial), rd,
                  {30'd0, (cont || !expTimed(r - 1 - e, p, s)), expTimed(r - 1 - e, p, s)});
      busWrite(ch, 0, (ctrl & ~32'h4) | 32'h8, x);
      busWrite(ch, 1, 32'd1, x);
    end

    // reset in the middle of a running count
    busWrite(3, 2, 32'd5, w);
    busWrite(3, 0, 32'h0007, e);
    idleTo(e + 9);
    busRead(3, 2, rd, r);
    checkOutput("ch3 period before reset", rd, 32'd5);
    checkOutput("irq before reset", {31'd0, bus.irq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset readdata", bus.readdata, 32'd0);
    checkOutput("mid reset irq", {31'd0, bus.irq}, 32'd0);
    checkOutput("mid reset irq_vec", {28'd0, bus.irq_vec}, 32'd0);
    reset = 1'b0;
    busRead(3, 2, rd, r);
    checkOutput("ch3 period after reset", rd, 32'd49);
    busRead(3, 1, rd, r);
    checkOutput("ch3 status after reset", rd, 32'd0);
  endtask

  initial begin
    $display("[TB] starting gamesystem_multi_timer bench");
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
